// File: rtl/mm_lat_mem.sv
// -----------------------------------------------------------------------------
// mm_lat_mem -- line-organised memory model with a fixed read latency.
//
// Stores MEM_RANGE lines of LINE_W bits. Requests either move a whole line
// (fill/evict traffic) or, in bypass mode, a single WORD_W word with byte
// enables. A read captures its data when it is accepted and returns it
// RD_LAT cycles later with a one-cycle valid strobe. No request is taken
// while a read is waiting; such requests are dropped and flagged.
//
// Optional feature (compile-time macro MM_INIT_PATTERN_EN):
//   defined   -> reset loads every word with {line[15:0], word[15:0]}
//   undefined -> reset leaves memory untouched (powers up as X)
//
// Parameters
//   LINE_W    line width in bits (multiple of WORD_W)
//   WORD_W    bypass word width in bits
//   ADDR_W    byte address width
//   MEM_RANGE number of lines (power of two, >= 2)
//   RD_LAT    read latency in cycles (>= 1)
//
// Ports
//   clk    in   clock, all state changes on rising edge
//   reset  in   asynchronous active-high reset
//   a      in   byte address
//   read   in   read request
//   write  in   write request
//   wd     in   write data (bypass uses [WORD_W-1:0])
//   be     in   byte enables (bypass only)
//   bypass in   word-access mode select
//   rd     out  read data, held outside the response cycle
//   valid  out  one-cycle read-data strobe
//   busy   out  read in flight, requests not accepted
//   err    out  sticky protocol-error flag
// -----------------------------------------------------------------------------
module mm_lat_mem #(
  parameter int LINE_W    = 256,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_RANGE = 256,
  parameter int RD_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     a,
  input  logic                  read,
  input  logic                  write,
  input  logic [LINE_W-1:0]     wd,
  input  logic [WORD_W/8-1:0]   be,
  input  logic                  bypass,
  output logic [LINE_W-1:0]     rd,
  output logic                  valid,
  output logic                  busy,
  output logic                  err
);

  localparam int WORD_BYTES = WORD_W / 8;
  localparam int WORDS      = LINE_W / WORD_W;
  localparam int OFF_W      = $clog2(LINE_W / 8);
  localparam int IDX_W      = $clog2(MEM_RANGE);
  localparam int WSEL_LO    = $clog2(WORD_BYTES);
  localparam int WSEL_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W      = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

  // Remaining WAIT cycles loaded on an accepted read; WAIT lasts CNT_INIT+1.
  localparam logic [CNT_W-1:0] CNT_INIT = (RD_LAT >= 2) ? CNT_W'(RD_LAT - 2) : '0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] snap;
  logic [LINE_W-1:0] mem [MEM_RANGE];

  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] word_sel;
  logic              accept;
  logic              do_write;
  logic              do_read;
  logic [LINE_W-1:0] line_next;
  logic [WORD_W-1:0] read_word;
  logic [LINE_W-1:0] read_data;
  logic              unused_addr;

  // Upper address bits wrap and byte-offset bits are don't-care by design.
  assign unused_addr = ^a;

  assign idx = a[OFF_W+IDX_W-1:OFF_W];

  // A line holding a single word has no word-select field in the address.
  if (WORDS > 1) begin : g_wsel
    assign word_sel = a[OFF_W-1:WSEL_LO];
  end else begin : g_wsel_single
    assign word_sel = '0;
  end

  assign busy  = (state == WAIT);
  assign valid = (state == RESP);

  assign accept   = !busy;
  assign do_write = accept && write;
  // A simultaneous read is a protocol error and the write takes priority.
  assign do_read  = accept && read && !write;

  // Merge incoming data into the addressed line: whole line, or only the
  // enabled bytes of the selected word in bypass mode.
  always_comb begin
    line_next = mem[idx];
    if (bypass) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be[b]) begin
          line_next[int'(word_sel) * WORD_W + b * 8 +: 8] = wd[b * 8 +: 8];
        end
      end
    end else begin
      line_next = wd;
    end
  end

  // Data a read would capture right now: the line, or the zero-extended word.
  always_comb begin
    read_word = mem[idx][int'(word_sel) * WORD_W +: WORD_W];
    read_data = bypass ? LINE_W'(read_word) : mem[idx];
  end

`ifdef MM_INIT_PATTERN_EN
  // Memory array with a recognisable reset image for bring-up/debug.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_RANGE; i++) begin
        for (int w = 0; w < WORDS; w++) begin
          mem[i][w * WORD_W +: WORD_W] <= WORD_W'({i[15:0], w[15:0]});
        end
      end
    end else if (do_write) begin
      mem[idx] <= line_next;
    end
  end
`else
  // Plain memory array: contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[idx] <= line_next;
    end
  end
`endif

  // Request sequencing, read snapshot, response data and the error flag.
  // rd is only loaded on entry to RESP, so it holds between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      snap  <= '0;
      rd    <= '0;
      err   <= 1'b0;
    end else begin
      if ((read || write) && busy) begin
        err <= 1'b1;
      end
      if (accept && read && write) begin
        err <= 1'b1;
      end

      case (state)
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            rd    <= snap;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (do_read) begin
            snap <= read_data;
            if (RD_LAT == 1) begin
              state <= RESP;
              rd    <= read_data;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_lat_mem.sv
// -----------------------------------------------------------------------------
// tb_mm_lat_mem -- self-checking bench for mm_lat_mem.
//
// Memory contents are tracked as a flat byte array indexed by
// line*LINE_BYTES + byte offset; expected lines and words are assembled from
// it with plain address arithmetic. Directed scenarios cover latency, bypass
// byte merge, address wrap, dropped requests, read+write collision and reset
// during a read; a randomized phase mixes line/word reads and writes.
// -----------------------------------------------------------------------------
module tb_mm_lat_mem;

  localparam int LINE_W     = 256;
  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int MEM_RANGE  = 256;
  localparam int RD_LAT     = 4;
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int WORD_BYTES = WORD_W / 8;
  localparam int WORDS      = LINE_W / WORD_W;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [ADDR_W-1:0]       a;
  logic                    read;
  logic                    write;
  logic [LINE_W-1:0]       wd;
  logic [WORD_BYTES-1:0]   be;
  logic                    bypass;
  logic [LINE_W-1:0]       rd;
  logic                    valid;
  logic                    busy;
  logic                    err;

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned model_bytes [MEM_RANGE * LINE_BYTES];

  mm_lat_mem #(
    .LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W),
    .MEM_RANGE(MEM_RANGE), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .a(a), .read(read), .write(write),
    .wd(wd), .be(be), .bypass(bypass), .rd(rd), .valid(valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int lineOf(input logic [ADDR_W-1:0] addr);
    return int'((addr / LINE_BYTES) % MEM_RANGE);
  endfunction

  function automatic int wordOf(input logic [ADDR_W-1:0] addr);
    return int'((addr / WORD_BYTES) % WORDS);
  endfunction

  function automatic void modelWriteLine(input logic [ADDR_W-1:0] addr,
                                         input logic [LINE_W-1:0] data);
    for (int k = 0; k < LINE_BYTES; k++)
      model_bytes[lineOf(addr) * LINE_BYTES + k] = data[k * 8 +: 8];
  endfunction

  function automatic void modelWriteWord(input logic [ADDR_W-1:0] addr,
                                         input logic [LINE_W-1:0] data,
                                         input logic [WORD_BYTES-1:0] ben);
    for (int b = 0; b < WORD_BYTES; b++)
      if (ben[b])
        model_bytes[lineOf(addr) * LINE_BYTES + wordOf(addr) * WORD_BYTES + b] = data[b * 8 +: 8];
  endfunction

  function automatic logic [LINE_W-1:0] modelReadLine(input logic [ADDR_W-1:0] addr);
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_BYTES; k++)
      v[k * 8 +: 8] = model_bytes[lineOf(addr) * LINE_BYTES + k];
    return v;
  endfunction

  function automatic logic [LINE_W-1:0] modelReadWord(input logic [ADDR_W-1:0] addr);
    logic [LINE_W-1:0] v;
    v = '0;
    for (int b = 0; b < WORD_BYTES; b++)
      v[b * 8 +: 8] = model_bytes[lineOf(addr) * LINE_BYTES + wordOf(addr) * WORD_BYTES + b];
    return v;
  endfunction

  function automatic logic [LINE_W-1:0] randLine();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k * 32 +: 32] = $urandom;
    return v;
  endfunction

  // Lines 0..7, any byte offset, with random aliasing upper bits.
  function automatic logic [ADDR_W-1:0] randAddr();
    return ADDR_W'($urandom_range(0, 7) * LINE_BYTES + $urandom_range(0, LINE_BYTES - 1)
                   + $urandom_range(0, 15) * LINE_BYTES * MEM_RANGE);
  endfunction

  // ---------------- bench tasks ----------------
  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] obs,
                             input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request for the next rising edge; returns at the following
  // falling edge with the request lines cleared.
  task automatic applyStimulus(input logic r, input logic w, input logic byp,
                               input logic [ADDR_W-1:0] addr,
                               input logic [LINE_W-1:0] data,
                               input logic [WORD_BYTES-1:0] ben);
    read = r; write = w; bypass = byp; a = addr; wd = data; be = ben;
    @(posedge clk);
    @(negedge clk);
    read = 1'b0; write = 1'b0; bypass = 1'b0; be = '0;
  endtask

  // Called right after a read was applied; stops on the valid cycle.
  task automatic waitResponse(input string tag, input logic [LINE_W-1:0] expected);
    int lat;
    int busy_cycles;
    lat = 1;
    busy_cycles = 0;
    while (!valid && lat < 16) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, LINE_W'(lat), LINE_W'(RD_LAT));
    checkOutput({tag, " busy cycles"}, LINE_W'(busy_cycles), LINE_W'(RD_LAT - 1));
    checkOutput({tag, " rd"}, rd, expected);
  endtask

  task automatic countValids(input int n, output int cnt, output logic [LINE_W-1:0] last_rd);
    cnt = 0;
    last_rd = '0;
    for (int i = 0; i < n; i++) begin
      if (valid) begin
        cnt++;
        last_rd = rd;
      end
      @(negedge clk);
    end
  endtask

  task automatic lineWrite(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data);
    applyStimulus(1'b0, 1'b1, 1'b0, addr, data, '0);
    modelWriteLine(addr, data);
  endtask

  task automatic wordWrite(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                           input logic [WORD_BYTES-1:0] ben);
    applyStimulus(1'b0, 1'b1, 1'b1, addr, data, ben);
    modelWriteWord(addr, data, ben);
  endtask

  task automatic lineRead(input string tag, input logic [ADDR_W-1:0] addr);
    logic [LINE_W-1:0] exp;
    exp = modelReadLine(addr);
    applyStimulus(1'b1, 1'b0, 1'b0, addr, '0, '0);
    waitResponse(tag, exp);
  endtask

  task automatic wordRead(input string tag, input logic [ADDR_W-1:0] addr);
    logic [LINE_W-1:0] exp;
    exp = modelReadWord(addr);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, '0, '0);
    waitResponse(tag, exp);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int nv;
    logic [LINE_W-1:0] last;
    logic [LINE_W-1:0] exp;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;

    reset = 1'b1; read = 1'b0; write = 1'b0; bypass = 1'b0;
    a = '0; wd = '0; be = '0;

    @(negedge clk);
    checkOutput("reset valid", LINE_W'(valid), '0);
    checkOutput("reset busy", LINE_W'(busy), '0);
    checkOutput("reset err", LINE_W'(err), '0);
    checkOutput("reset rd", rd, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic line write then read with full latency and single valid.
    lineWrite(32'h40, {4{64'h0123456789ABCDEF}});
    lineRead("line 0x40", 32'h40);
    @(negedge clk);
    checkOutput("single valid pulse", LINE_W'(valid), '0);
    checkOutput("rd held after resp", rd, {4{64'h0123456789ABCDEF}});

    // Bypass byte merge into word 1 of line 2.
    lineWrite(32'h40, {LINE_W{1'b1}});
    wordWrite(32'h44, LINE_W'(32'hDEADBEEF), 4'b0011);
    wordRead("bypass 0x44", 32'h44);
    checkOutput("bypass literal", rd, LINE_W'(32'hFFFFBEEF));

    // Address wrap onto line 0.
    lineWrite(32'h0, {32{8'hAA}});
    lineRead("wrap 0x2000", 32'h2000);
    checkOutput("wrap literal", rd, {32{8'hAA}});

    // Back-to-back reads: second one accepted in the response cycle.
    lineRead("b2b first", 32'h40);
    lineRead("b2b second", 32'h0);

    // Randomized phase over lines 0..7.
    for (int l = 0; l < 8; l++) lineWrite(ADDR_W'(l * LINE_BYTES), randLine());
    for (int i = 0; i < 60; i++) begin
      addr = randAddr();
      data = randLine();
      case ($urandom_range(0, 3))
        0: lineWrite(addr, data);
        1: wordWrite(addr, data, WORD_BYTES'($urandom_range(0, 15)));
        2: lineRead("rand line read", addr);
        default: wordRead("rand word read", addr);
      endcase
    end
    @(negedge clk);
    checkOutput("err clean after legal traffic", LINE_W'(err), '0);

    // Read issued while busy is dropped and flagged.
    exp = modelReadLine(32'h20);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h20, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h40, '0, '0);
    countValids(10, nv, last);
    checkOutput("dropped read valid count", LINE_W'(nv), LINE_W'(1));
    checkOutput("dropped read data", last, exp);
    checkOutput("dropped read err", LINE_W'(err), LINE_W'(1));

    // Read and write together: write only, no valid.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h80, {32{8'h5A}}, '0);
    modelWriteLine(32'h80, {32{8'h5A}});
    countValids(6, nv, last);
    checkOutput("rw collision valid count", LINE_W'(nv), '0);
    checkOutput("rw collision err", LINE_W'(err), LINE_W'(1));
    lineRead("rw collision readback", 32'h80);

    // Reset during WAIT aborts the read.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h20, '0, '0);
    checkOutput("pre-reset busy", LINE_W'(busy), LINE_W'(1));
    #2 reset = 1'b1;
    #1;
    checkOutput("mid-read reset busy", LINE_W'(busy), '0);
    checkOutput("mid-read reset valid", LINE_W'(valid), '0);
    checkOutput("mid-read reset err", LINE_W'(err), '0);
    checkOutput("mid-read reset rd", rd, '0);
    @(negedge clk);
    reset = 1'b0;
    countValids(8, nv, last);
    checkOutput("aborted read valid count", LINE_W'(nv), '0);

`ifdef MM_INIT_PATTERN_EN
    for (int w = 0; w < WORDS; w++) exp[w * WORD_W +: WORD_W] = WORD_W'({16'h0001, 16'(w)});
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h20, '0, '0);
    waitResponse("init pattern line 1", exp);
`else
    lineRead("memory kept over reset", 32'h80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_lat_mem.md
MM_LAT_MEM -- requirements
Module: mm_lat_mem

Interface
REQ-001 SHALL have parameter LINE_W, default 256, fill/evict line width in bits; multiple of WORD_W.
REQ-002 SHALL have parameter WORD_W, default 32, bypass word width in bits.
REQ-003 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-004 SHALL have parameter MEM_RANGE, default 256, line count; power of two, at least 2.
REQ-005 SHALL have parameter RD_LAT, default 4, read latency in cycles; at least 1.
REQ-006 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-008 SHALL have port a, input, ADDR_W, byte address.
REQ-009 SHALL have port read, input, 1, read request.
REQ-010 SHALL have port write, input, 1, write request.
REQ-011 SHALL have port wd, input, LINE_W, write data; bypass mode uses only [WORD_W-1:0].
REQ-012 SHALL have port be, input, WORD_W/8, byte enables; used in bypass mode only.
REQ-013 SHALL have port bypass, input, 1, word-access mode select.
REQ-014 SHALL have port rd, output, LINE_W, read data.
REQ-015 SHALL have port valid, output, 1, one-cycle read-data strobe.
REQ-016 SHALL have port busy, output, 1, read in flight; requests not accepted.
REQ-017 SHALL have port err, output, 1, sticky protocol-error flag.

Function
REQ-018 SHALL use line index = a[OFF_W+IDX_W-1:OFF_W], where OFF_W = log2(LINE_W/8) and IDX_W = log2(MEM_RANGE); higher address bits are ignored, so addresses wrap modulo MEM_RANGE lines.
REQ-019 SHALL select the word in bypass mode with a[OFF_W-1:log2(WORD_W/8)]; byte offset bits are ignored.
REQ-020 SHALL implement states IDLE, WAIT and RESP; busy = (state==WAIT).
REQ-021 SHALL accept a request only on a rising edge where busy is 0, i.e. in IDLE or RESP.
REQ-022 Line write: SHALL write all LINE_W bits of wd to the indexed line on the accept edge.
REQ-023 Bypass write: SHALL update only the enabled bytes of the selected word from wd[WORD_W-1:0].
REQ-024 Read: SHALL snapshot the indexed line, or in bypass mode the zero-extended selected word in rd[WORD_W-1:0], on the accept edge, so later writes do not alter the returned data.
REQ-025 SHALL, after a read is accepted, go to WAIT for RD_LAT-1 cycles, then RESP for 1 cycle, then IDLE; with RD_LAT=1 it SHALL go directly to RESP.
REQ-026 SHALL drive valid=1 and rd=snapshot only in RESP; rd SHALL hold its last value outside RESP.
REQ-027 SHALL allow back-to-back reads: a read accepted in RESP SHALL give the next valid exactly RD_LAT cycles later.
REQ-028 SHALL ignore read or write while busy and SHALL set err.
REQ-029 SHALL, when read and write are both high on an accept edge, perform the write only, produce no valid, and set err.
REQ-030 SHALL clear err only on reset.

Reset
REQ-031 SHALL, while reset is high, asynchronously force state=IDLE, valid=0, busy=0, err=0, rd=0 and the latency counter=0.
REQ-032 SHALL, if reset is asserted mid-read, abort the read with no valid pulse after reset is released.
REQ-033 SHALL leave memory contents untouched on reset, except as specified in REQ-034.

Configuration
REQ-034 SHALL, with macro MM_INIT_PATTERN_EN defined, initialise every word on reset as line i, word w = {i[15:0], w[15:0]}; without the macro, memory SHALL NOT change on reset and SHALL power up as X.

Verification
REQ-035 Line write a=0x40, wd=256'h0123..EF; read a=0x40 -> busy high 3 cycles, valid a single cycle 4 cycles after accept, rd=written data.
REQ-036 Line 0x40 all-ones; bypass write a=0x44, be=4'b0011, wd=0xDEADBEEF; bypass read a=0x44 -> rd[31:0]=0xFFFFBEEF, rd[255:32]=0.
REQ-037 Read a=0x20 accepted; read a=0x40 issued during WAIT -> ignored, err=1, exactly one valid pulse.
REQ-038 read=write=1 at a=0x80, wd=0x5A.. -> no valid, err=1; a later read of 0x80 returns 0x5A..
REQ-039 Write line 0 = 0xAA..; read a=0x2000 -> returns 0xAA.. (wraps to line 0).
REQ-040 Reset asserted in WAIT -> busy=0 and valid=0 immediately; no valid pulse after release; with MM_INIT_PATTERN_EN, read a=0x20 then returns word w = 0x0001_000w.
